right_rotator: RTL and testbench

Parameterised N-bit barrel rotator. It rotates operand A right by B positions: bits shifted out of the LSB re-enter at the MSB. It is built from log2(N) mux stages, one per bit of B, and drives a registered output. It is a leaf datapath block for the barrel-shifter family, used wherever a single-cycle registered rotate is needed.

---
 rtl/right_rotator.sv | 56 +++++
 tb/tb_right_rotator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/right_rotator.sv
// rtl/right_rotator.sv - N-bit barrel rotate-right with one registered output stage
module right_rotator #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] B,
    output logic          out_valid,
    output logic [N-1:0]  Y
);

    // Reject widths the log2 stage cascade cannot cover exactly.
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("right_rotator: N must be a power of two and at least 2");
    end
    if (SW != $clog2(N)) begin : g_bad_sw
        $error("right_rotator: SW is derived from N and must not be overridden");
    end

    // stage_w[0] is the raw operand; stage_w[k+1] is stage k's output.
    logic [N-1:0] stage_w [0:SW];
    logic [N-1:0] y_d;
    logic [N-1:0] y_q;
    logic         valid_q;

    assign stage_w[0] = A;

    // Stage k rotates right by 2^k when B[k] is set, LSB stage first.
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage_w[k+1] = B[k] ? {stage_w[k][SH-1:0], stage_w[k][N-1:SH]}
                                   : stage_w[k];
    end

    assign y_d = stage_w[SW];

    // Capture the rotated value on valid input; otherwise hold Y and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                y_q <= y_d;
            end
        end
    end

    assign Y         = y_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_right_rotator.sv
// tb/tb_right_rotator.sv - self-checking bench for right_rotator at N=8 and N=32
module tb_right_rotator;

    logic        clk;
    logic        rst_n;
    logic        in_valid8;
    logic [7:0]  a8;
    logic [2:0]  b8;
    logic        ov8;
    logic [7:0]  y8;
    logic        in_valid32;
    logic [31:0] a32;
    logic [4:0]  b32;
    logic        ov32;
    logic [31:0] y32;

    int checks = 0;
    int errors = 0;

    right_rotator #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
        .A(a8), .B(b8), .out_valid(ov8), .Y(y8)
    );

    right_rotator #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32),
        .A(a32), .B(b32), .out_valid(ov32), .Y(y32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotation straight from the formula (A>>B)|(A<<(N-B)) mod 2^N.
    function automatic logic [7:0] ref8(input logic [7:0] a, input int b);
        logic [15:0] w;
        w = ({8'h00, a} >> b) | ({8'h00, a} << (8 - b));
        return w[7:0];
    endfunction

    function automatic logic [31:0] ref32(input logic [31:0] a, input int b);
        logic [63:0] w;
        w = ({32'h0, a} >> b) | ({32'h0, a} << (32 - b));
        return w[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: what each output must hold after every edge / reset.
    logic        m_ov8  = 1'b0;
    logic [7:0]  m_y8   = 8'h00;
    logic        m_ov32 = 1'b0;
    logic [31:0] m_y32  = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov8  = 1'b0;
            m_y8   = 8'h00;
            m_ov32 = 1'b0;
            m_y32  = 32'h0;
        end else begin
            m_ov8 = in_valid8;
            if (in_valid8) m_y8 = ref8(a8, int'(b8));
            m_ov32 = in_valid32;
            if (in_valid32) m_y32 = ref32(a32, int'(b32));
        end
    end

    // Compare every cycle, mid-period, away from the active edge.
    always @(negedge clk) begin
        check("model_ov8",  {31'h0, ov8},  {31'h0, m_ov8});
        check("model_y8",   {24'h0, y8},   {24'h0, m_y8});
        check("model_ov32", {31'h0, ov32}, {31'h0, m_ov32});
        check("model_y32",  y32,           m_y32);
    end

    task automatic drive8(input logic v, input logic [7:0] a, input logic [2:0] b);
        in_valid8 = v;
        a8        = a;
        b8        = b;
    endtask

    logic [7:0] sweep_exp [0:7];

    initial begin
        sweep_exp = '{8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0, 8'h60, 8'h30, 8'h18};
        rst_n      = 1'b1;
        in_valid8  = 1'b0;
        a8         = 8'h00;
        b8         = 3'd0;
        in_valid32 = 1'b0;
        a32        = 32'h0;
        b32        = 5'd0;

        // Reset asserted with a valid all-ones operand present.
        #1;
        drive8(1'b1, 8'hFF, 3'd3);
        rst_n = 1'b0;
        #1;
        check("rst_async_y",  {24'h0, y8},  32'h00);
        check("rst_async_ov", {31'h0, ov8}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y",  {24'h0, y8},  32'h00);
        check("rst_hold_ov", {31'h0, ov8}, 32'h0);
        drive8(1'b0, 8'hFF, 3'd3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_y",  {24'h0, y8},  32'h00);
        check("post_rst_ov", {31'h0, ov8}, 32'h0);

        // Full sweep of B with A=0x0C, one per cycle.
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 8'h0C, 3'(i));
            @(posedge clk);
            #1;
            check($sformatf("sweep_y_b%0d", i), {24'h0, y8}, {24'h0, sweep_exp[i]});
            check("sweep_ov", {31'h0, ov8}, 32'h1);
        end

        // Wrap and identity cases.
        drive8(1'b1, 8'h01, 3'd1);
        @(posedge clk); #1;
        check("wrap_01_b1", {24'h0, y8}, 32'h80);
        drive8(1'b1, 8'hA5, 3'd0);
        @(posedge clk); #1;
        check("ident_a5_b0", {24'h0, y8}, 32'hA5);
        drive8(1'b1, 8'h80, 3'd7);
        @(posedge clk); #1;
        check("wrap_80_b7", {24'h0, y8}, 32'h01);

        // Hold: one valid result, then three idle cycles with changing operands.
        drive8(1'b1, 8'h3C, 3'd2);
        @(posedge clk); #1;
        check("hold_first_y",  {24'h0, y8},  32'h0F);
        check("hold_first_ov", {31'h0, ov8}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive8(1'b0, 8'h11 * 8'(i + 1), 3'(i + 4));
            @(posedge clk); #1;
            check("hold_y",  {24'h0, y8},  32'h0F);
            check("hold_ov", {31'h0, ov8}, 32'h0);
        end

        // Mid-stream reset pulse between edges while valid data streams in.
        drive8(1'b1, 8'hF0, 3'd1);
        @(posedge clk); #1;
        check("stream_y", {24'h0, y8}, 32'h78);
        drive8(1'b1, 8'h0F, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_y",  {24'h0, y8},  32'h00);
        check("mid_rst_ov", {31'h0, ov8}, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_y",  {24'h0, y8},  32'hC3);
        check("after_rst_ov", {31'h0, ov8}, 32'h1);

        // Random back-to-back traffic on both widths, checked by the model.
        for (int i = 0; i < 1000; i++) begin
            in_valid8  = ($urandom_range(0, 7) != 0);
            a8         = 8'($urandom);
            b8         = 3'($urandom_range(0, 7));
            in_valid32 = ($urandom_range(0, 7) != 0);
            a32        = $urandom;
            b32        = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
        end
        in_valid8  = 1'b0;
        in_valid32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
